// File: rtl/interrupt_source_controller_if.sv
// Bus bundle between the interrupt source controller and its peripheral/core side.
// Carries requests, config writes, ack/EOI pulses and the registered request outputs.
interface interrupt_source_controller_if #(
    parameter int NUM_SRC = 8,
    parameter int ID_W    = 3
);
    logic [NUM_SRC-1:0] IntReq;
    logic               CfgWrite;
    logic [1:0]         CfgAddr;
    logic [NUM_SRC-1:0] CfgData;
    logic               FiqAck;
    logic               IrqAck;
    logic               FiqEoi;
    logic               IrqEoi;
    logic               Fiq;
    logic               Irq;
    logic [ID_W-1:0]    FiqId;
    logic [ID_W-1:0]    IrqId;
    logic [NUM_SRC-1:0] Pending;

    modport master (
        output IntReq, CfgWrite, CfgAddr, CfgData,
        output FiqAck, IrqAck, FiqEoi, IrqEoi,
        input  Fiq, Irq, FiqId, IrqId, Pending
    );

    modport slave (
        input  IntReq, CfgWrite, CfgAddr, CfgData,
        input  FiqAck, IrqAck, FiqEoi, IrqEoi,
        output Fiq, Irq, FiqId, IrqId, Pending
    );
endinterface

// File: rtl/interrupt_source_controller.sv
// Interrupt source controller: latches peripheral requests, routes them to FIQ/IRQ,
// and runs an IDLE/ASSERT/ACTIVE handshake per channel with lowest-index priority.
// Ports: clock, reset (async active-low), bus (slave): IntReq, Cfg*, *Ack, *Eoi in;
//        Fiq, Irq, FiqId, IrqId, Pending out (all registered).
module interrupt_source_controller #(
    parameter int NUM_SRC = 8,
    parameter int ID_W    = 3
) (
    input  logic clock,
    input  logic reset,
    interrupt_source_controller_if.slave bus
);
    typedef enum logic [1:0] {
        ST_IDLE,
        ST_ASSERT,
        ST_ACTIVE
    } state_t;

    // Channel index 0 is FIQ, 1 is IRQ.
    logic [NUM_SRC-1:0] r_enable;
    logic [NUM_SRC-1:0] r_fiq_sel;
    logic [NUM_SRC-1:0] r_edge_mode;
    logic [NUM_SRC-1:0] r_pending;
    logic [NUM_SRC-1:0] r_prev;

    state_t          r_state     [2];
    state_t          w_state_nxt [2];
    logic [1:0]      r_req;
    logic [1:0]      w_req_nxt;
    logic [ID_W-1:0] r_id        [2];
    logic [ID_W-1:0] w_id_nxt    [2];

    logic [NUM_SRC-1:0] w_cand [2];
    logic [1:0]         w_ack;
    logic [1:0]         w_eoi;
    logic [NUM_SRC-1:0] w_set;
    logic [NUM_SRC-1:0] w_clr;
    logic [NUM_SRC-1:0] w_pending_nxt;

    function automatic logic [ID_W-1:0] f_win(input logic [NUM_SRC-1:0] v);
        f_win = '0;
        for (int i = NUM_SRC - 1; i >= 0; i--) begin
            if (v[i]) f_win = ID_W'(i);
        end
    endfunction

    assign w_ack     = {bus.IrqAck, bus.FiqAck};
    assign w_eoi     = {bus.IrqEoi, bus.FiqEoi};
    assign w_cand[0] = r_pending & r_fiq_sel;
    assign w_cand[1] = r_pending & ~r_fiq_sel;

    // Only the source presented in the ack cycle is cleared, and only if edge-mode.
    always_comb begin
        w_clr = '0;
        for (int c = 0; c < 2; c++) begin
            if (r_state[c] == ST_ASSERT && w_ack[c]) begin
                w_clr[r_id[c]] = 1'b1;
            end
        end
    end

    // Edge set beats a simultaneous ack clear.
    assign w_set = bus.IntReq & ~r_prev & r_enable;
    assign w_pending_nxt =
        (r_edge_mode & (w_set | (r_pending & ~w_clr))) |
        (~r_edge_mode & bus.IntReq & r_enable);

    always_comb begin
        for (int c = 0; c < 2; c++) begin
            w_state_nxt[c] = r_state[c];
            w_req_nxt[c]   = r_req[c];
            w_id_nxt[c]    = r_id[c];
            unique case (r_state[c])
                ST_IDLE: begin
                    if (|w_cand[c]) begin
                        w_state_nxt[c] = ST_ASSERT;
                        w_req_nxt[c]   = 1'b1;
                        w_id_nxt[c]    = f_win(w_cand[c]);
                    end
                end
                ST_ASSERT: begin
                    if (w_ack[c]) begin
                        // ID freezes at the value the core saw.
                        w_state_nxt[c] = ST_ACTIVE;
                        w_req_nxt[c]   = 1'b0;
                    end else if (!(|w_cand[c])) begin
                        w_state_nxt[c] = ST_IDLE;
                        w_req_nxt[c]   = 1'b0;
                    end else begin
                        w_id_nxt[c] = f_win(w_cand[c]);
                    end
                end
                ST_ACTIVE: begin
                    if (w_eoi[c]) begin
                        w_state_nxt[c] = ST_IDLE;
                    end
                end
                default: begin
                    w_state_nxt[c] = ST_IDLE;
                    w_req_nxt[c]   = 1'b0;
                end
            endcase
        end
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            r_enable    <= '0;
            r_fiq_sel   <= '0;
            r_edge_mode <= '0;
        end else if (bus.CfgWrite) begin
            case (bus.CfgAddr)
                2'd0:    r_enable    <= bus.CfgData;
                2'd1:    r_fiq_sel   <= bus.CfgData;
                2'd2:    r_edge_mode <= bus.CfgData;
                default: ;
            endcase
        end
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            r_pending <= '0;
            r_prev    <= '0;
        end else begin
            r_pending <= w_pending_nxt;
            r_prev    <= bus.IntReq;
        end
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            r_req <= '0;
            for (int c = 0; c < 2; c++) begin
                r_state[c] <= ST_IDLE;
                r_id[c]    <= '0;
            end
        end else begin
            r_req <= w_req_nxt;
            for (int c = 0; c < 2; c++) begin
                r_state[c] <= w_state_nxt[c];
                r_id[c]    <= w_id_nxt[c];
            end
        end
    end

    assign bus.Fiq     = r_req[0];
    assign bus.Irq     = r_req[1];
    assign bus.FiqId   = r_id[0];
    assign bus.IrqId   = r_id[1];
    assign bus.Pending = r_pending;

endmodule

// File: tb/tb_interrupt_source_controller.sv
// Testbench for interrupt_source_controller: directed scenarios plus random traffic,
// compared every cycle against a rule-level reference model.
module tb_interrupt_source_controller;
    logic clock;
    logic reset;
    int   checks;
    int   failures;

    interrupt_source_controller_if #(.NUM_SRC(8), .ID_W(3)) bus ();

    interrupt_source_controller #(.NUM_SRC(8), .ID_W(3)) dut (
        .clock (clock),
        .reset (reset),
        .bus   (bus.slave)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    // Reference model: config, pending, edge history, and per-channel
    // "request up" / "in service" flags with the presented source ID.
    bit [7:0] m_en, m_fsel, m_mode, m_pend, m_hist;
    bit       m_req [2];
    bit       m_svc [2];
    int       m_id  [2];

    function automatic int lowest(input bit [7:0] v);
        for (int i = 0; i < 8; i++) if (v[i]) return i;
        return -1;
    endfunction

    always @(posedge clock or negedge reset) begin : model
        bit [7:0] nxt, clr, cand;
        int       win;
        bit       ack, eoi;
        if (!reset) begin
            m_en = 0; m_fsel = 0; m_mode = 0; m_pend = 0; m_hist = 0;
            for (int c = 0; c < 2; c++) begin
                m_req[c] = 0; m_svc[c] = 0; m_id[c] = 0;
            end
        end else begin
            clr = 0;
            for (int c = 0; c < 2; c++) begin
                ack = (c == 0) ? bus.FiqAck : bus.IrqAck;
                if (m_req[c] && ack && m_mode[m_id[c]]) clr[m_id[c]] = 1;
            end
            for (int i = 0; i < 8; i++) begin
                if (m_mode[i])
                    nxt[i] = (bus.IntReq[i] && !m_hist[i] && m_en[i]) ||
                             (m_pend[i] && !clr[i]);
                else
                    nxt[i] = bus.IntReq[i] && m_en[i];
            end
            for (int c = 0; c < 2; c++) begin
                ack  = (c == 0) ? bus.FiqAck : bus.IrqAck;
                eoi  = (c == 0) ? bus.FiqEoi : bus.IrqEoi;
                cand = (c == 0) ? (m_pend & m_fsel) : (m_pend & ~m_fsel);
                win  = lowest(cand);
                if (m_svc[c]) begin
                    if (eoi) m_svc[c] = 0;
                end else if (m_req[c]) begin
                    if (ack) begin
                        m_req[c] = 0;
                        m_svc[c] = 1;
                    end else if (win < 0) begin
                        m_req[c] = 0;
                    end else begin
                        m_id[c] = win;
                    end
                end else if (win >= 0) begin
                    m_req[c] = 1;
                    m_id[c]  = win;
                end
            end
            if (bus.CfgWrite) begin
                if (bus.CfgAddr == 2'd0) m_en   = bus.CfgData;
                if (bus.CfgAddr == 2'd1) m_fsel = bus.CfgData;
                if (bus.CfgAddr == 2'd2) m_mode = bus.CfgData;
            end
            m_pend = nxt;
            m_hist = bus.IntReq;
        end
    end

    task automatic chk(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    always @(negedge clock) begin
        chk("m_fiq",   bus.Fiq,     m_req[0]);
        chk("m_irq",   bus.Irq,     m_req[1]);
        chk("m_fiqid", bus.FiqId,   m_id[0]);
        chk("m_irqid", bus.IrqId,   m_id[1]);
        chk("m_pend",  bus.Pending, m_pend);
    end

    task automatic tick();
        @(posedge clock);
        #2;
    endtask

    task automatic cfg(input logic [1:0] a, input logic [7:0] d);
        bus.CfgWrite = 1'b1;
        bus.CfgAddr  = a;
        bus.CfgData  = d;
        tick();
        bus.CfgWrite = 1'b0;
    endtask

    task automatic irq_ack();
        bus.IrqAck = 1'b1; tick(); bus.IrqAck = 1'b0;
    endtask

    task automatic irq_eoi();
        bus.IrqEoi = 1'b1; tick(); bus.IrqEoi = 1'b0;
    endtask

    initial begin
        checks = 0;
        failures = 0;
        reset = 1'b0;
        bus.IntReq = 8'hFF;
        bus.CfgWrite = 0; bus.CfgAddr = 0; bus.CfgData = 0;
        bus.FiqAck = 0; bus.IrqAck = 0; bus.FiqEoi = 0; bus.IrqEoi = 0;

        // Reset with all requests high
        repeat (2) tick();
        chk("rst_fiq", bus.Fiq, 1'b0);
        chk("rst_irq", bus.Irq, 1'b0);
        chk("rst_pend", bus.Pending, 8'h00);
        reset = 1'b1;
        repeat (3) tick();
        chk("dis_pend", bus.Pending, 8'h00);
        chk("dis_irq", bus.Irq, 1'b0);
        chk("dis_fiq", bus.Fiq, 1'b0);
        bus.IntReq = 8'h00;

        // Level IRQ with preemption, ack freeze, EOI re-assert
        cfg(2'd0, 8'h30);
        bus.IntReq = 8'h20; tick();
        chk("l_pend5", bus.Pending, 8'h20);
        chk("l_irq0", bus.Irq, 1'b0);
        bus.IntReq = 8'h30; tick();
        chk("l_irq1", bus.Irq, 1'b1);
        chk("l_id5", bus.IrqId, 3'd5);
        tick();
        chk("l_id4", bus.IrqId, 3'd4);
        irq_ack();
        chk("l_ack_irq", bus.Irq, 1'b0);
        chk("l_ack_id", bus.IrqId, 3'd4);
        bus.IntReq = 8'h20;
        repeat (2) tick();
        chk("l_act_irq", bus.Irq, 1'b0);
        chk("l_act_id", bus.IrqId, 3'd4);
        irq_eoi();
        chk("l_eoi_irq", bus.Irq, 1'b0);
        tick();
        chk("l_re_irq", bus.Irq, 1'b1);
        chk("l_re_id", bus.IrqId, 3'd5);
        bus.IntReq = 8'h00;
        repeat (2) tick();
        chk("l_drop", bus.Irq, 1'b0);

        // Simultaneous FIQ and IRQ
        cfg(2'd1, 8'h01);
        cfg(2'd0, 8'h03);
        bus.IntReq = 8'h03;
        repeat (2) tick();
        chk("d_fiq", bus.Fiq, 1'b1);
        chk("d_fiqid", bus.FiqId, 3'd0);
        chk("d_irq", bus.Irq, 1'b1);
        chk("d_irqid", bus.IrqId, 3'd1);
        bus.FiqAck = 1'b1; tick(); bus.FiqAck = 1'b0;
        chk("d_fack_fiq", bus.Fiq, 1'b0);
        chk("d_fack_irq", bus.Irq, 1'b1);
        bus.FiqEoi = 1'b1; tick(); bus.FiqEoi = 1'b0;
        bus.IntReq = 8'h00;
        repeat (3) tick();
        chk("d_idle_f", bus.Fiq, 1'b0);
        chk("d_idle_i", bus.Irq, 1'b0);

        // Edge mode on source 2
        cfg(2'd1, 8'h00);
        cfg(2'd2, 8'h04);
        cfg(2'd0, 8'h04);
        bus.IntReq = 8'h04; tick();
        bus.IntReq = 8'h00; tick();
        chk("e_hold", bus.Pending, 8'h04);
        chk("e_irq", bus.Irq, 1'b1);
        chk("e_id", bus.IrqId, 3'd2);
        tick();
        chk("e_hold2", bus.Pending, 8'h04);
        irq_ack();
        chk("e_clr", bus.Pending, 8'h00);
        irq_eoi();
        bus.IntReq = 8'h04; tick();
        bus.IntReq = 8'h00; tick();
        chk("e_irq2", bus.Irq, 1'b1);
        bus.IntReq = 8'h04;
        irq_ack();
        bus.IntReq = 8'h00;
        chk("e_setwin", bus.Pending, 8'h04);
        chk("e_ack_irq", bus.Irq, 1'b0);

        // Disable in-service source: stays active until EOI
        cfg(2'd0, 8'h00);
        repeat (3) tick();
        chk("a_irq", bus.Irq, 1'b0);
        chk("a_id", bus.IrqId, 3'd2);
        chk("a_pend", bus.Pending, 8'h04);
        irq_eoi();
        tick();
        chk("a_re_irq", bus.Irq, 1'b1);
        irq_eoi();
        chk("a_stray_eoi", bus.Irq, 1'b1);
        irq_ack();
        chk("a_ack_pend", bus.Pending, 8'h00);
        irq_eoi();
        irq_ack();
        tick();
        chk("a_stray_ack", bus.Irq, 1'b0);
        cfg(2'd0, 8'h04);
        bus.IntReq = 8'h04; tick();
        bus.IntReq = 8'h00; tick();
        chk("a_idle_ok", bus.Irq, 1'b1);
        irq_ack();
        irq_eoi();
        cfg(2'd2, 8'h00);

        // Async reset while IRQ asserted and FIQ active
        cfg(2'd1, 8'h01);
        cfg(2'd0, 8'h03);
        bus.IntReq = 8'h03;
        repeat (2) tick();
        bus.FiqAck = 1'b1; tick(); bus.FiqAck = 1'b0;
        chk("r_pre_fiq", bus.Fiq, 1'b0);
        chk("r_pre_irq", bus.Irq, 1'b1);
        #1 reset = 1'b0;
        #1;
        chk("r_irq", bus.Irq, 1'b0);
        chk("r_fiq", bus.Fiq, 1'b0);
        chk("r_pend", bus.Pending, 8'h00);
        chk("r_irqid", bus.IrqId, 3'd0);
        chk("r_fiqid", bus.FiqId, 3'd0);
        tick();
        reset = 1'b1;
        repeat (2) tick();
        chk("r_cfg_irq", bus.Irq, 1'b0);
        chk("r_cfg_fiq", bus.Fiq, 1'b0);
        bus.IntReq = 8'h00;

        // Random traffic
        for (int n = 0; n < 4000; n++) begin
            if ($urandom_range(3) == 0) bus.IntReq = 8'($urandom);
            bus.CfgWrite = ($urandom_range(15) == 0);
            bus.CfgAddr  = 2'($urandom_range(3));
            bus.CfgData  = 8'($urandom);
            bus.FiqAck   = ($urandom_range(3) == 0);
            bus.IrqAck   = ($urandom_range(3) == 0);
            bus.FiqEoi   = ($urandom_range(5) == 0);
            bus.IrqEoi   = ($urandom_range(5) == 0);
            if (n == 2000) begin
                #1 reset = 1'b0;
                #1 reset = 1'b1;
            end
            tick();
        end
        bus.CfgWrite = 0; bus.FiqAck = 0; bus.IrqAck = 0;
        bus.FiqEoi = 0; bus.IrqEoi = 0;
        tick();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/interrupt_source_controller.md
# interrupt_source_controller

Peripheral-side interrupt controller driving the core's Fiq and Irq request lines: latches up to NUM_SRC peripheral requests, applies per-source enable, FIQ/IRQ routing and edge/level mode, selects the highest-priority pending source per channel, and holds the request until the core acknowledges. It is the request source for the core's FiqDisable/IrqDisable masking and priority logic. On acknowledge it freezes the serviced source ID, and on end-of-interrupt (EOI) it re-arms the channel.

## Interface
- NUM_SRC, 8: number of peripheral sources (2..32).
- ID_W, 3: source-ID width, must equal ceil(log2(NUM_SRC)).
- clock  in  1  single clock; all state updates on the rising edge.
- reset  in  1  asynchronous, active-low reset.
- IntReq  in  NUM_SRC  peripheral requests, synchronous to clock.
- CfgWrite  in  1  config write strobe.
- CfgAddr  in  2  0=Enable, 1=FiqSelect (1 routes source to FIQ), 2=EdgeMode (1=rising-edge), 3=reserved (write ignored).
- CfgData  in  NUM_SRC  config write data.
- FiqAck, IrqAck  in  1 each  one-cycle pulse from the core on taking the exception.
- FiqEoi, IrqEoi  in  1 each  one-cycle end-of-interrupt pulse.
- Fiq, Irq  out  1 each  registered requests to the core.
- FiqId, IrqId  out  ID_W each  registered source ID of the current request or in-service source.
- Pending  out  NUM_SRC  registered pending vector.

## Operation
- Reset: Enable, FiqSelect, EdgeMode, Pending, and the edge-history register are all 0. Fiq=Irq=0, FiqId=IrqId=0. Both channels are in IDLE.
- Config write: register updated at the clock edge when CfgWrite=1; takes effect from the next cycle.
- Level source: Pending[i] <= IntReq[i] & Enable[i] each cycle.
- Edge source: Pending[i] is set on IntReq[i]=1 with previous sample 0 and Enable[i]=1. It is cleared only when that source is acked. If set and clear occur in the same cycle, set wins.
- Candidate set: FIQ channel uses Pending & FiqSelect; IRQ channel uses Pending & ~FiqSelect. Priority is fixed: lowest index wins.
- Per-channel FSM (FIQ shown; IRQ identical with its own signals):
  - IDLE: if the candidate set is non-empty, go to ASSERT with Fiq<=1 and FiqId<=winner.
  - ASSERT:
    - FiqId tracks the current winner each cycle, so a higher-priority arrival preempts the ID.
    - If candidates vanish (level drop or disable), go to IDLE with Fiq<=0.
    - On FiqAck, go to ACTIVE with Fiq<=0; FiqId freezes at the value presented in the ack cycle, and an edge-mode source's pending bit is cleared.
  - ACTIVE:
    - Fiq held 0; FiqId frozen.
    - No nesting: new candidates, including higher-priority ones, wait.
    - On FiqEoi, go to IDLE.
- Ignored inputs: Ack in IDLE or ACTIVE; Eoi in IDLE or ASSERT.
- Channel independence: the FIQ and IRQ FSMs run independently, so an IRQ may assert while FIQ is ACTIVE. Prioritising FIQ over IRQ is the core's job.
- Reconfiguration in ACTIVE (disable or re-route of the in-service source) does not abort service; the channel waits for EOI.

## Timing
- IntReq rise to Pending: 1 cycle.
- Pending to Fiq/Irq high: 1 more cycle, so IntReq to request latency is 2 cycles.
- Ack to request low: 1 cycle. The ID is stable from the ack cycle until EOI.
- Eoi to IDLE: 1 cycle. If a candidate is pending, the request re-asserts 1 cycle after that (EOI to re-assert = 2 cycles).
- Edge sources: minimum IntReq low time between detected edges is 1 cycle.
- Asynchronous reset mid-operation: all outputs go to their reset values immediately. Pending edges are lost.

## Test plan
- Reset with IntReq=8'hFF: Fiq=Irq=0, Pending=0. After release with Enable=0, all outputs stay 0.
- Enable=8'h30, level mode, FiqSelect=0; raise IntReq[5] then IntReq[4] one cycle later:
  - Irq=1 two cycles after IntReq[5].
  - IrqId moves 5→4.
  - IrqAck freezes IrqId=4 and Irq drops next cycle.
  - IrqEoi with IntReq[5] still high re-asserts Irq with IrqId=5.
- FiqSelect=8'h01, Enable=8'h03, both requests high: Fiq=1/FiqId=0 and Irq=1/IrqId=1 in the same cycle. FiqAck does not affect Irq.
- EdgeMode=8'h04, pulse IntReq[2] for 1 cycle: Pending[2] holds after IntReq falls. Ack clears it. A new edge during the ack cycle keeps Pending[2]=1.
- ACTIVE channel: set Enable=0 for the in-service source; the channel stays ACTIVE until Eoi. Stray Ack in IDLE and stray Eoi in ASSERT cause no state change.
- Drop reset while Irq=1 and FIQ is ACTIVE: all outputs go to 0 immediately and config is cleared.
